// File: rtl/testing_pkg.sv
// Shared types for the ALU arbiter slice: opcodes, arbiter FSM states and
// the operand bundle handed to the sequential ALU.
package testing_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    MULT = 3'd2,
    DIV  = 3'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [7:0] op1;
    logic [7:0] op2;
    opcode_e    opcode;
  } alu_req_t;

endpackage

// File: rtl/alu_seq.sv
// Single-cycle registered 8-bit signed ALU; result updates only on in_valid
// and otherwise holds, so the caller can present it for as long as needed.
module alu_seq
  import testing_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  alu_req_t   in_req,
  output logic [7:0] result
);

  logic signed [15:0] a, b, prod, quo;
  logic [7:0]         nxt;

  always_comb begin
    a    = {{8{in_req.op1[7]}}, in_req.op1};
    b    = {{8{in_req.op2[7]}}, in_req.op2};
    prod = a * b;
    // 16-bit divide keeps -128/-1 well defined before truncation; /0 guarded
    quo  = (b == 16'sd0) ? 16'sd0 : a / b;
    nxt  = 8'd0;
    case (in_req.opcode)
      ADD:     nxt = in_req.op1 + in_req.op2;
      SUB:     nxt = in_req.op1 - in_req.op2;
      MULT:    nxt = prod[7:0];
      DIV:     nxt = quo[7:0];
      default: nxt = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)           result <= 8'd0;
    else if (in_valid) result <= nxt;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one sequential ALU among NREQ requesters:
// IDLE grants, EXEC runs the ALU for one cycle, RESP holds the result.
module alu_arbiter
  import testing_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic    [NREQ-1:0]        req_valid,
  output logic    [NREQ-1:0]        req_ready,
  input  logic    [NREQ-1:0][7:0]   req_op1,
  input  logic    [NREQ-1:0][7:0]   req_op2,
  input  opcode_e [NREQ-1:0]        req_opcode,
  output logic    [NREQ-1:0]        resp_valid,
  input  logic    [NREQ-1:0]        resp_ready,
  output logic    [7:0]             resp_data,
  output logic                      resp_err,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  arb_state_e     state;
  logic [IW-1:0]  rr_ptr, g, pick;
  alu_req_t       lat;
  logic           div0;
  logic [7:0]     alu_result;

  // First valid requester at or after ptr, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] sel;
    logic          found;
    int            j;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && v[j]) begin
        sel   = IW'(j);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick      = rr_pick(req_valid, rr_ptr);
    req_ready = '0;
    if (!rst && state == IDLE && |req_valid) req_ready = NREQ'(1) << pick;
    // div-by-zero never forwards the ALU output
    resp_data = (state == RESP && !div0) ? alu_result : 8'd0;
    resp_err  = (state == RESP) && div0;
  end

  alu_seq u_alu (
    .clk      (clk),
    .rst      (rst),
    .in_valid (state == EXEC),
    .in_req   (lat),
    .result   (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      g          <= '0;
      lat        <= '0;
      div0       <= 1'b0;
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          g          <= pick;
          lat.op1    <= req_op1[pick];
          lat.op2    <= req_op2[pick];
          lat.opcode <= req_opcode[pick];
          div0       <= (req_opcode[pick] == DIV) && (req_op2[pick] == 8'd0);
          busy       <= 1'b1;
          state      <= EXEC;
        end
        EXEC: begin
          resp_valid <= NREQ'(1) << g;
          state      <= RESP;
        end
        RESP: if (resp_ready[g]) begin
          resp_valid <= '0;
          busy       <= 1'b0;
          rr_ptr     <= (g == IW'(NREQ-1)) ? '0 : g + IW'(1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, round-robin order, ALU corner
// cases, back-pressure in RESP, and reset while an operation is in flight.
module tb_alu_arbiter;
  import testing_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic    [3:0]        req_valid;
  logic    [3:0]        req_ready;
  logic    [3:0][7:0]   req_op1, req_op2;
  opcode_e [3:0]        req_opcode;
  logic    [3:0]        resp_valid;
  logic    [3:0]        resp_ready;
  logic    [7:0]        resp_data;
  logic                 resp_err;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with requests already driven; req_valid stays as is.
  task automatic run_op(input string tag, input int eg, input logic [7:0] ed, input logic ee);
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(4'b1 << eg));
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
    tick();
    chk({tag, ".exec_busy"}, 32'(busy), 32'd1);
    chk({tag, ".exec_rdy"}, 32'(req_ready), 32'd0);
    chk({tag, ".exec_rv"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(4'b1 << eg));
    chk({tag, ".resp_data"}, 32'(resp_data), 32'(ed));
    chk({tag, ".resp_err"}, 32'(resp_err), 32'(ee));
    resp_ready = 4'(4'b1 << eg);
    tick();
    resp_ready = 4'b0;
    chk({tag, ".done_rv"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_opcode = {ADD, ADD, ADD, ADD};
    tick(); tick();
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_data", 32'(resp_data), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Single request, 5 + 7 on requester 1
    req_op1[1] = 8'd5; req_op2[1] = 8'd7; req_opcode[1] = ADD;
    req_valid = 4'b0010;
    run_op("add5_7", 1, 8'd12, 1'b0);
    req_valid = '0;
    chk("add5_7.idle_busy", 32'(busy), 32'd0);

    // Fresh reset so rr_ptr = 0, then all four contend
    rst = 1'b1; tick(); rst = 1'b0;
    req_op1[0] = 8'd127;  req_op2[0] = 8'd1;  req_opcode[0] = ADD;
    req_op1[1] = 8'd16;   req_op2[1] = 8'd16; req_opcode[1] = MULT;
    req_op1[2] = 8'd9;    req_op2[2] = 8'd0;  req_opcode[2] = DIV;
    req_op1[3] = 8'hF9;   req_op2[3] = 8'd2;  req_opcode[3] = DIV;
    req_valid = 4'b1111;
    run_op("rr0_add127", 0, 8'h80, 1'b0);
    run_op("rr1_mul16",  1, 8'h00, 1'b0);
    run_op("rr2_div0",   2, 8'h00, 1'b1);
    run_op("rr3_divneg", 3, 8'hFD, 1'b0);
    run_op("rr4_wrap",   0, 8'h80, 1'b0);
    req_valid = '0;

    // Back-pressure: rr_ptr = 1, requester 2 does 3 - 5
    req_op1[2] = 8'd3; req_op2[2] = 8'd5; req_opcode[2] = SUB;
    req_valid = 4'b0100;
    #1;
    chk("hold.grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1011;
    tick();
    resp_ready = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      chk("hold.rv", 32'(resp_valid), 32'b0100);
      chk("hold.data", 32'(resp_data), 32'hFE);
      chk("hold.req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = '0;
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    chk("hold.release_busy", 32'(busy), 32'd0);
    chk("hold.release_rv", 32'(resp_valid), 32'd0);

    // rr_ptr = 3: grant requester 3, reset while in EXEC
    req_opcode[3] = ADD;
    req_valid = 4'b1000;
    #1;
    chk("rstexec.grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstexec.busy", 32'(busy), 32'd0);
    chk("rstexec.rv", 32'(resp_valid), 32'd0);
    tick();
    chk("rstexec.rv2", 32'(resp_valid), 32'd0);
    chk("rstexec.busy2", 32'(busy), 32'd0);
    // rr_ptr back at 0: lowest valid (2) wins over 3
    req_op1[2] = 8'd9; req_op2[2] = 8'd0; req_opcode[2] = DIV;
    req_valid = 4'b1100;
    run_op("rstexec.next", 2, 8'h00, 1'b1);

    // Unknown opcode on requester 3 (rr_ptr = 3)
    req_opcode[3] = opcode_e'(3'd5);
    req_op1[3] = 8'd20; req_op2[3] = 8'd3;
    req_valid = 4'b1000;
    run_op("badop", 3, 8'h00, 1'b0);
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
